beep_sched: RTL and testbench
=============================

// Module: beep_sched
// PURPOSE
//   Scheduler/arbiter sharing one PWM buzzer between NUM_REQ tone requesters
//   (song player, key click, alarm). Fixed priority: index 0 is highest.
//   Grants one request at a time and plays its square wave for a tick-counted
//   duration. Then inserts a silent gap and returns to arbitration.
// PARAMETERS
//   NUM_REQ  4        number of requesters
//   PER_W    16       tone period width, in clk cycles
//   DUR_W    8        duration width, in ticks
//   TICK_MAX 499_999  tick = TICK_MAX+1 clk cycles (10 ms at 50 MHz)
//   GAP_TICK 2        silent ticks after each tone (0 = no gap)
// PORTS
//   clk      in   1              system clock
//   rst_n    in   1              async active-low reset
//   req      in   NUM_REQ        level request; hold until ack
//   period   in   NUM_REQ*PER_W  tone period per req, slice i = [i*PER_W+:PER_W]
//   dur      in   NUM_REQ*DUR_W  duration per req, in ticks
//   ack      out  NUM_REQ        1-cycle pulse: request i accepted, inputs latched
//   done     out  NUM_REQ        1-cycle pulse: request i finished or aborted
//   abort    out  1              pulses with done when the end was a preemption
//   busy     out  1              1 whenever state != IDLE
//   gnt_id   out  clog2(NUM_REQ) index of the current/last granted requester
//   beep     out  1              registered PWM output to the buzzer
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, all counters 0. Reset is async at any time.
//     Reset during PLAY silences beep at once and produces no done.
//   FSM IDLE -> PLAY -> GAP -> IDLE.
//   IDLE: if req != 0 at edge k, then at edge k+1:
//     - i = lowest set bit of req; ack[i]=1 for 1 cycle; gnt_id=i
//     - period[i] and dur[i] latched; tick_cnt, freq_cnt cleared; state PLAY
//   req[i] still high after done[i] counts as a new request.
//   PLAY:
//     - freq_cnt counts 0..per_l, then wraps to 0
//     - beep <= (freq_cnt >= per_l>>1), registered, so 1 cycle behind the count
//     - per_l = 0 is a rest: beep held 0 for the full duration
//     - tick_cnt counts 0..TICK_MAX and wraps; each wrap decrements dur_cnt
//     - tone lasts exactly dur_l*(TICK_MAX+1) cycles after ack
//     - on the last cycle: done[gnt_id]=1, beep<=0, state GAP
//       (GAP_TICK=0: state IDLE)
//     - dur_l = 0: done pulses the cycle after ack; beep never goes high
//   GAP: beep=0 for GAP_TICK*(TICK_MAX+1) cycles, then IDLE. Requests arriving
//     during PLAY/GAP are held off (no ack) until IDLE and arbitrated there.
//   Simultaneous reqs in IDLE: lowest index wins. Others wait with no ack.
//   ack and done never pulse in the same cycle.
//   Width rules: counters sized to PER_W / DUR_W / clog2(TICK_MAX+1);
//     per_l>>1 is a truncating shift.
// CONFIGURATION
//   BEEP_PREEMPT_EN defined:
//     - in PLAY, req[j] with j < gnt_id aborts the current tone
//     - next edge: done[gnt_id]=1, abort=1, beep<=0, GAP skipped, state IDLE
//     - ack[j] follows one cycle later through normal arbitration
//     - a tone on its last cycle completes normally (abort=0)
//   BEEP_PREEMPT_EN undefined: no preemption; abort is tied 0.
// TESTING  (TICK_MAX=9, GAP_TICK=2, NUM_REQ=4)
//   1. Reset mid-PLAY: rst_n low -> beep=0, busy=0, ack=done=0 the same cycle.
//   2. req[2], period=8, dur=3: ack[2] 1 cycle later; beep period 9 cycles,
//      high 5 / low 4; done[2] 30 cycles after ack; busy low 20 cycles later.
//   3. req=4'b1010 in IDLE: ack[1] first; after done[1]+gap, ack[3].
//   4. period=0, dur=2: beep stays 0; done 20 cycles after ack.
//      dur=0: done exactly 1 cycle after ack.
//   5. req[0] raised mid-PLAY of req[3]: undefined macro -> req[0] waits for
//      done[3]+gap; macro defined -> done[3]&abort next edge, ack[0] edge after.
//   6. req[1] held high through done[1]: re-acked after the gap (repeat play).

Source files
------------

// File: rtl/beep_sched.sv
// -----------------------------------------------------------------------------
// beep_sched
//   Shares one PWM buzzer between NUM_REQ tone requesters using fixed priority
//   (index 0 highest). A granted request has its period and duration latched,
//   then plays a square wave for dur*(TICK_MAX+1) clock cycles. A silent gap of
//   GAP_TICK ticks follows before the scheduler arbitrates again.
//
//   Optional feature (compile-time macro BEEP_PREEMPT_EN):
//     defined   - a higher-priority request aborts the tone being played
//                 (done + abort pulse, gap skipped).
//     undefined - no preemption; abort is tied low.
//
// Ports
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   req     in   [NUM_REQ]        level requests, held until ack
//   period  in   [NUM_REQ*PER_W]  tone period per requester (slice i)
//   dur     in   [NUM_REQ*DUR_W]  tone duration per requester, in ticks
//   ack     out  [NUM_REQ]        1-cycle pulse: request accepted, inputs latched
//   done    out  [NUM_REQ]        1-cycle pulse: request finished or aborted
//   abort   out                   pulses with done when the tone was preempted
//   busy    out                   high whenever the scheduler is not idle
//   gnt_id  out  [ID_W]           index of the current/last granted requester
//   beep    out                   registered PWM drive to the buzzer
// -----------------------------------------------------------------------------
module beep_sched #(
   parameter int NUM_REQ  = 4,
   parameter int PER_W    = 16,
   parameter int DUR_W    = 8,
   parameter int TICK_MAX = 499_999,
   parameter int GAP_TICK = 2,
   localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*PER_W-1:0] period,
   input  logic [NUM_REQ*DUR_W-1:0] dur,
   output logic [NUM_REQ-1:0]       ack,
   output logic [NUM_REQ-1:0]       done,
   output logic                     abort,
   output logic                     busy,
   output logic [ID_W-1:0]          gnt_id,
   output logic                     beep
);

   localparam int TICK_W = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
   localparam int GAP_W  = (GAP_TICK > 0) ? $clog2(GAP_TICK + 1) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_MAX);
   localparam logic [GAP_W-1:0]  GAP_INIT  = GAP_W'(GAP_TICK);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t              state_reg, state_next;
   logic [PER_W-1:0]    per_reg, per_next;
   logic [DUR_W-1:0]    dur_reg, dur_next;
   logic [TICK_W-1:0]   tick_reg, tick_next;
   logic [PER_W-1:0]    freq_reg, freq_next;
   logic [GAP_W-1:0]    gap_reg, gap_next;
   logic [ID_W-1:0]     gnt_reg, gnt_next;
   logic [NUM_REQ-1:0]  ack_reg, ack_next;
   logic [NUM_REQ-1:0]  done_reg, done_next;
   logic                beep_reg, beep_next;

   logic [PER_W-1:0]    per_arr [NUM_REQ];
   logic [DUR_W-1:0]    dur_arr [NUM_REQ];
   logic [ID_W-1:0]     win_id;
   logic                tick_wrap;
   logic                play_last;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign per_arr[gi] = period[gi*PER_W +: PER_W];
         assign dur_arr[gi] = dur[gi*DUR_W +: DUR_W];
      end
   endgenerate

   // Lowest set bit wins: scanning downwards lets the lowest index overwrite.
   always_comb begin
      win_id = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            win_id = ID_W'(i);
         end
      end
   end

   assign tick_wrap = (tick_reg == TICK_LAST);
   // dur=0 ends right after the ack; otherwise the final tick wrap ends it.
   assign play_last = (dur_reg == '0) || ((dur_reg == DUR_W'(1)) && tick_wrap);

`ifdef BEEP_PREEMPT_EN
   logic preempt;
   logic abort_reg, abort_next;

   always_comb begin
      preempt = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req[i] && (ID_W'(i) < gnt_reg)) begin
            preempt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         abort_reg <= 1'b0;
      end else begin
         abort_reg <= abort_next;
      end
   end

   assign abort = abort_reg;
`else
   assign abort = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      per_next   = per_reg;
      dur_next   = dur_reg;
      tick_next  = tick_reg;
      freq_next  = freq_reg;
      gap_next   = gap_reg;
      gnt_next   = gnt_reg;
      ack_next   = '0;
      done_next  = '0;
      beep_next  = 1'b0;
`ifdef BEEP_PREEMPT_EN
      abort_next = 1'b0;
`endif
      case (state_reg)
         IDLE: begin
            tick_next = '0;
            freq_next = '0;
            if (req != '0) begin
               state_next       = PLAY;
               gnt_next         = win_id;
               ack_next[win_id] = 1'b1;
               per_next         = per_arr[win_id];
               dur_next         = dur_arr[win_id];
            end
         end
         PLAY: begin
            if (play_last) begin
               // A tone on its final cycle always completes normally.
               done_next[gnt_reg] = 1'b1;
               tick_next          = '0;
               gap_next           = GAP_INIT;
               state_next         = (GAP_TICK == 0) ? IDLE : GAP;
            end
`ifdef BEEP_PREEMPT_EN
            else if (preempt) begin
               done_next[gnt_reg] = 1'b1;
               abort_next         = 1'b1;
               tick_next          = '0;
               state_next         = IDLE;
            end
`endif
            else begin
               tick_next = tick_wrap ? '0 : tick_reg + 1'b1;
               if (tick_wrap) begin
                  dur_next = dur_reg - 1'b1;
               end
               freq_next = (freq_reg == per_reg) ? '0 : freq_reg + 1'b1;
               // Period 0 is a rest; otherwise high for the upper part of the count.
               beep_next = (per_reg != '0) && (freq_reg >= (per_reg >> 1));
            end
         end
         GAP: begin
            if (tick_wrap && (gap_reg == GAP_W'(1))) begin
               state_next = IDLE;
               tick_next  = '0;
            end else begin
               tick_next = tick_wrap ? '0 : tick_reg + 1'b1;
               if (tick_wrap) begin
                  gap_next = gap_reg - 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         per_reg   <= '0;
         dur_reg   <= '0;
         tick_reg  <= '0;
         freq_reg  <= '0;
         gap_reg   <= '0;
         gnt_reg   <= '0;
         ack_reg   <= '0;
         done_reg  <= '0;
         beep_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         per_reg   <= per_next;
         dur_reg   <= dur_next;
         tick_reg  <= tick_next;
         freq_reg  <= freq_next;
         gap_reg   <= gap_next;
         gnt_reg   <= gnt_next;
         ack_reg   <= ack_next;
         done_reg  <= done_next;
         beep_reg  <= beep_next;
      end
   end

   assign ack    = ack_reg;
   assign done   = done_reg;
   assign beep   = beep_reg;
   assign gnt_id = gnt_reg;
   assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_beep_sched.sv
// -----------------------------------------------------------------------------
// tb_beep_sched
//   Scoreboard bench for beep_sched with TICK_MAX=9 (10-cycle tick) and
//   GAP_TICK=2 (20-cycle gap). The stimulus process drives requests on falling
//   edges and queues the expected ack/done events and beep/busy samples, each
//   stamped with the cycle in which it must be seen. A monitor on the falling
//   edge pops and compares whenever the DUT pulses ack/done or a sample is due.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_beep_sched;

   localparam int NUM_REQ  = 4;
   localparam int PER_W    = 16;
   localparam int DUR_W    = 8;
   localparam int TICK_MAX = 9;
   localparam int GAP_TICK = 2;

   logic                     clk    = 1'b0;
   logic                     rst_n  = 1'b0;
   logic [NUM_REQ-1:0]       req    = '0;
   logic [NUM_REQ*PER_W-1:0] period = '0;
   logic [NUM_REQ*DUR_W-1:0] dur    = '0;
   logic [NUM_REQ-1:0]       ack;
   logic [NUM_REQ-1:0]       done;
   logic                     abort;
   logic                     busy;
   logic [1:0]               gnt_id;
   logic                     beep;

   beep_sched #(
      .NUM_REQ (NUM_REQ),
      .PER_W   (PER_W),
      .DUR_W   (DUR_W),
      .TICK_MAX(TICK_MAX),
      .GAP_TICK(GAP_TICK)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .period(period),
      .dur   (dur),
      .ack   (ack),
      .done  (done),
      .abort (abort),
      .busy  (busy),
      .gnt_id(gnt_id),
      .beep  (beep)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int kind;   // 0 = ack, 1 = done
      int id;
      bit ab;
   } ev_t;

   typedef struct {
      int cyc;
      bit cb;     // compare beep
      bit beep;
      bit cy;     // compare busy
      bit busy;
   } smp_t;

   ev_t  evq[$];
   smp_t sq[$];
   int   n_vec  = 0;
   int   n_err  = 0;
   bit   tb_end = 1'b0;

   task automatic push_ev(input int k, input int id, input int c, input bit ab);
      ev_t e;
      e.cyc = c; e.kind = k; e.id = id; e.ab = ab;
      evq.push_back(e);
   endtask

   task automatic push_smp(input int c, input bit cb, input bit bv, input bit cy, input bit yv);
      smp_t s;
      s.cyc = c; s.cb = cb; s.beep = bv; s.cy = cy; s.busy = yv;
      sq.push_back(s);
   endtask

   task automatic set_tone(input int id, input int per, input int d);
      period[id*PER_W +: PER_W] = per[PER_W-1:0];
      dur[id*DUR_W +: DUR_W]    = d[DUR_W-1:0];
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // ---------------------------------------------------------------- monitor
   logic [NUM_REQ-1:0] mon_v;
   logic [NUM_REQ-1:0] mon_oh;
   ev_t                mon_e;
   smp_t               mon_s;

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         mon_v = (k == 0) ? ack : done;
         if (mon_v != '0) begin
            n_vec++;
            if (evq.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_%s cyc=%0d got=%b abort=%b required=none",
                        (k == 0) ? "ack" : "done", cyc, mon_v, abort);
            end else begin
               mon_e  = evq.pop_front();
               mon_oh = '0;
               mon_oh[mon_e.id] = 1'b1;
               if (mon_e.kind != k || mon_v != mon_oh || mon_e.cyc != cyc ||
                   abort != mon_e.ab || (k == 0 && gnt_id != 2'(mon_e.id))) begin
                  n_err++;
                  $display("FAIL %s_id%0d got kind=%0d vec=%b cyc=%0d abort=%b gnt=%0d required kind=%0d vec=%b cyc=%0d abort=%b",
                           (k == 0) ? "ack" : "done", mon_e.id, k, mon_v, cyc, abort, gnt_id,
                           mon_e.kind, mon_oh, mon_e.cyc, mon_e.ab);
               end else begin
                  $display("%s id=%0d cyc=%0d abort=%b ok", (k == 0) ? "ack " : "done",
                           mon_e.id, cyc, abort);
               end
            end
         end
      end
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
         mon_e = evq.pop_front();
         n_vec++;
         n_err++;
         $display("FAIL missing_%s_id%0d got=none required cyc=%0d",
                  (mon_e.kind == 0) ? "ack" : "done", mon_e.id, mon_e.cyc);
      end
      while (sq.size() > 0 && sq[0].cyc <= cyc) begin
         mon_s = sq.pop_front();
         n_vec++;
         if (mon_s.cyc != cyc || (mon_s.cb && beep != mon_s.beep) ||
             (mon_s.cy && busy != mon_s.busy)) begin
            n_err++;
            $display("FAIL sample_cyc%0d got beep=%b busy=%b at cyc=%0d required beep=%b busy=%b",
                     mon_s.cyc, beep, busy, cyc, mon_s.beep, mon_s.busy);
         end
      end
      if (tb_end) begin
         n_vec++;
         if (evq.size() != 0 || sq.size() != 0) begin
            n_err++;
            $display("FAIL pending_at_end got events=%0d samples=%0d required 0 0",
                     evq.size(), sq.size());
         end
         $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
         $finish;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // --------------------------------------------------------------- stimulus
   initial begin
      int c, a, d, a2, d2;
      @(negedge clk);
      // Reset state: silent and idle.
      push_smp(cyc + 1, 1, 0, 1, 0);
      push_smp(cyc + 2, 1, 0, 1, 0);
      wait_cyc(cyc + 3);
      rst_n = 1'b1;

      // req[2], period 8, dur 3: 9-cycle beep, high 5 / low 4, done 30 after ack.
      c = cyc; set_tone(2, 8, 3); req = 4'b0100;
      a = c + 1; d = a + 30;
      push_ev(0, 2, a, 0);
      push_ev(1, 2, d, 0);
      for (int n = 0; n <= 30; n++) begin
         push_smp(a + n, 1, (n >= 1 && n <= 29 && ((n - 1) % 9) >= 4), 0, 0);
      end
      push_smp(d + 19, 0, 0, 1, 1);
      push_smp(d + 20, 0, 0, 1, 0);
      wait_cyc(a); req = '0;
      wait_cyc(d + 21);

      // req=1010: index 1 first, index 3 after done[1] plus gap.
      c = cyc; set_tone(1, 4, 1); set_tone(3, 6, 2); req = 4'b1010;
      a = c + 1; d = a + 10; a2 = d + 21; d2 = a2 + 20;
      push_ev(0, 1, a, 0);
      push_ev(1, 1, d, 0);
      push_ev(0, 3, a2, 0);
      push_ev(1, 3, d2, 0);
      wait_cyc(a); req = 4'b1000;
      wait_cyc(a2); req = '0;
      wait_cyc(d2 + 21);

      // Rest: period 0, dur 2 keeps beep low, done 20 after ack.
      c = cyc; set_tone(0, 0, 2); req = 4'b0001;
      a = c + 1; d = a + 20;
      push_ev(0, 0, a, 0);
      push_ev(1, 0, d, 0);
      for (int n = 0; n <= 20; n++) push_smp(a + n, 1, 0, 0, 0);
      wait_cyc(a); req = '0;
      wait_cyc(d + 21);

      // dur 0: done exactly one cycle after ack, beep never high.
      c = cyc; set_tone(0, 5, 0); req = 4'b0001;
      a = c + 1; d = a + 1;
      push_ev(0, 0, a, 0);
      push_ev(1, 0, d, 0);
      push_smp(a, 1, 0, 0, 0);
      push_smp(d, 1, 0, 1, 1);
      push_smp(d + 19, 0, 0, 1, 1);
      push_smp(d + 20, 0, 0, 1, 0);
      wait_cyc(a); req = '0;
      wait_cyc(d + 21);

      // req[0] raised mid-play of req[3].
      c = cyc; set_tone(3, 6, 3); set_tone(0, 4, 1); req = 4'b1000;
      a = c + 1;
      push_ev(0, 3, a, 0);
`ifdef BEEP_PREEMPT_EN
      d = a + 6; a2 = d + 1;
      push_ev(1, 3, d, 1);
      push_smp(d, 1, 0, 0, 0);
`else
      d = a + 30; a2 = d + 21;
      push_smp(a + 6, 1, 1, 0, 0);
      push_ev(1, 3, d, 0);
`endif
      d2 = a2 + 10;
      push_ev(0, 0, a2, 0);
      push_ev(1, 0, d2, 0);
      wait_cyc(a); req = '0;
      wait_cyc(a + 5); req = 4'b0001;
      wait_cyc(a2); req = '0;
      wait_cyc(d2 + 21);

      // req[1] held through done[1]: replayed after the gap.
      c = cyc; set_tone(1, 2, 1); req = 4'b0010;
      a = c + 1; d = a + 10; a2 = d + 21; d2 = a2 + 10;
      push_ev(0, 1, a, 0);
      push_ev(1, 1, d, 0);
      push_ev(0, 1, a2, 0);
      push_ev(1, 1, d2, 0);
      wait_cyc(a2); req = '0;
      wait_cyc(d2 + 21);

      // Reset mid-play: beep high, then reset just after an edge silences it at once.
      c = cyc; set_tone(2, 8, 3); req = 4'b0100;
      a = c + 1;
      push_ev(0, 2, a, 0);
      push_smp(a + 7, 1, 1, 1, 1);
      push_smp(a + 8, 1, 0, 1, 0);
      push_smp(a + 9, 1, 0, 1, 0);
      push_smp(a + 10, 1, 0, 1, 0);
      wait_cyc(a); req = '0;
      wait_cyc(a + 7);
      @(posedge clk);
      #1 rst_n = 1'b0;
      wait_cyc(a + 10);
      rst_n = 1'b1;
      push_smp(a + 13, 1, 0, 1, 0);
      wait_cyc(a + 40);
      tb_end = 1'b1;
   end

endmodule
